// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: rack-level system bus arbiter.
//
// Grants one ZG requester at a time (one-hot ZW permit) and watches each
// granted cycle for a memory answer (ROK/REN). If no answer arrives within
// TIMEOUT cycles it raises a TALARM pulse of ALARM_TICKS cycles. Every release
// is followed by a dead gap of GAP_TICKS cycles before the next grant.
//
// Build option: define SYSBUS_RR_EN for round-robin arbitration. A pointer
// then tracks the index after the last owner. With the macro undefined the
// arbiter is fixed priority (lowest index wins) and has no pointer register.
// All other timing is the same in both builds.
`timescale 1ns/1ps

module sysbus_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT     = 250,
    parameter int ALARM_TICKS = 3,
    parameter int GAP_TICKS   = 1,
    localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            __clk,
    input  logic            clo_,
    input  logic [NREQ-1:0] zg,
    input  logic            rok_,
    input  logic            ren_,
    output logic [NREQ-1:0] zw,
    output logic [OW-1:0]   owner,
    output logic            busy,
    output logic            talarm
);

    // Terminal counts, sized to the counters they are compared against.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] ALARM_LAST   = 3'(ALARM_TICKS - 1);
    localparam logic [1:0] GAP_LAST     = 2'(GAP_TICKS - 1);
    localparam logic [7:0] TIMER_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DONE,
        ST_ALARM,
        ST_GAP
    } state_e;

    state_e          state_q,     state_d;
    logic [NREQ-1:0] zw_q,        zw_d;
    logic [OW-1:0]   owner_q,     owner_d;
    logic            busy_q,      busy_d;
    logic            talarm_q,    talarm_d;
    logic [7:0]      timer_q,     timer_d;
    logic [2:0]      alarm_cnt_q, alarm_cnt_d;
    logic [1:0]      gap_cnt_q,   gap_cnt_d;
`ifdef SYSBUS_RR_EN
    logic [OW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic            hi_found;
    logic [OW-1:0]   hi_idx;
`endif

    logic            req_any;
    logic            answer;
    logic            owner_req;
    logic [OW-1:0]   win_idx;
    logic [NREQ-1:0] grant_vec;

    // Bus answer lines are active-low; either one ends the supervised cycle.
    assign answer    = ~rok_ | ~ren_;
    assign req_any   = |zg;
    // Only the owner's own request line can end or abort the current cycle.
    assign owner_req = zg[owner_q];

    // Winner selection among the current requests, plus its one-hot permit.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        win_idx   = '0;
        grant_vec = '0;
`ifdef SYSBUS_RR_EN
        hi_found  = 1'b0;
        hi_idx    = '0;
`endif
        // Scan high to low so the last hit is the lowest requesting index.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (zg[i]) begin
                win_idx = OW'(i);
`ifdef SYSBUS_RR_EN
                // Lowest requester at or after the pointer, if any.
                if (OW'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = OW'(i);
                end
`endif
            end
        end
`ifdef SYSBUS_RR_EN
        // Nothing at or after the pointer: wrap to the lowest requester.
        if (hi_found) begin
            win_idx = hi_idx;
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            grant_vec[i] = (OW'(i) == win_idx);
        end
    end

    // Next-state and next-output logic of the bus ownership state machine.
    always_comb begin
        state_d     = state_q;
        zw_d        = zw_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        talarm_d    = talarm_q;
        timer_d     = timer_q;
        alarm_cnt_d = alarm_cnt_q;
        gap_cnt_d   = gap_cnt_q;
`ifdef SYSBUS_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Grants only happen here, so an owner is never preempted.
                if (req_any) begin
                    state_d = ST_GRANT;
                    zw_d    = grant_vec;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                    timer_d = '0;
`ifdef SYSBUS_RR_EN
                    rr_ptr_d = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + OW'(1);
`endif
                end
            end

            ST_GRANT: begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 8'd1;
                end
                // Answer is checked first so it wins over a same-cycle timeout.
                if (answer) begin
                    state_d = ST_DONE;
                end else if (!owner_req) begin
                    // Owner gave up before any answer: release without alarm.
                    state_d   = ST_GAP;
                    zw_d      = '0;
                    busy_d    = 1'b0;
                    gap_cnt_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = ST_ALARM;
                    talarm_d    = 1'b1;
                    alarm_cnt_d = '0;
                end
            end

            ST_ALARM: begin
                // Permit stays held; answers arriving now are ignored.
                if (alarm_cnt_q == ALARM_LAST) begin
                    state_d  = ST_DONE;
                    talarm_d = 1'b0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 3'd1;
                end
            end

            ST_DONE: begin
                // Hold the permit until the owner drops its request.
                if (!owner_req) begin
                    state_d   = ST_GAP;
                    zw_d      = '0;
                    busy_d    = 1'b0;
                    gap_cnt_d = '0;
                end
            end

            ST_GAP: begin
                // Dead time between owners; pending requests simply stay high.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 2'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                zw_d     = '0;
                busy_d   = 1'b0;
                talarm_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; general clear drops everything at once.
    always_ff @(posedge __clk or negedge clo_) begin
        // NOTE: all state here is plain flops with no storage array, so every
        // register is cleared by the asynchronous reset, including the grant.
        if (!clo_) begin
            state_q     <= ST_IDLE;
            zw_q        <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            talarm_q    <= 1'b0;
            timer_q     <= '0;
            alarm_cnt_q <= '0;
            gap_cnt_q   <= '0;
`ifdef SYSBUS_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            zw_q        <= zw_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            talarm_q    <= talarm_d;
            timer_q     <= timer_d;
            alarm_cnt_q <= alarm_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef SYSBUS_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign zw     = zw_q;
    assign owner  = owner_q;
    assign busy   = busy_q;
    assign talarm = talarm_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed bench for sysbus_arbiter with a scoreboard of
// expected outputs. Expectations are pushed when a step is driven and popped
// when the DUT outputs are sampled 1 ns after the following rising edge.
`timescale 1ns/1ps

module tb_sysbus_arbiter;

    localparam int NREQ        = 4;
    localparam int TIMEOUT     = 250;
    localparam int ALARM_TICKS = 3;
    localparam int GAP_TICKS   = 1;

    // Expected winner for zg=0011 right after owner 0 was served.
`ifdef SYSBUS_RR_EN
    localparam logic [3:0] PRI_ZW  = 4'b0010;
    localparam logic [1:0] PRI_OWN = 2'd1;
`else
    localparam logic [3:0] PRI_ZW  = 4'b0001;
    localparam logic [1:0] PRI_OWN = 2'd0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] zw;
        logic [1:0] owner;
        logic       busy;
        logic       talarm;
    } exp_t;

    logic            __clk = 1'b0;
    logic            clo_;
    logic [NREQ-1:0] zg;
    logic            rok_;
    logic            ren_;
    logic [NREQ-1:0] zw;
    logic [1:0]      owner;
    logic            busy;
    logic            talarm;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    sysbus_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT     (TIMEOUT),
        .ALARM_TICKS (ALARM_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) dut (
        .__clk  (__clk),
        .clo_   (clo_),
        .zg     (zg),
        .rok_   (rok_),
        .ren_   (ren_),
        .zw     (zw),
        .owner  (owner),
        .busy   (busy),
        .talarm (talarm)
    );

    // 50 MHz clock.
    always #10 __clk = ~__clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic [3:0] zw_e,
                              input logic [1:0] own_e, input logic busy_e,
                              input logic tal_e);
        exp_t e;
        e.tag    = tag;
        e.zw     = zw_e;
        e.owner  = own_e;
        e.busy   = busy_e;
        e.talarm = tal_e;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs now.
    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty: observed=no entry required=entry");
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (zw === e.zw) else begin
                bad++;
                $error("FAIL %s.zw observed=%b required=%b", e.tag, zw, e.zw);
            end
            total++;
            assert (owner === e.owner) else begin
                bad++;
                $error("FAIL %s.owner observed=%0d required=%0d", e.tag, owner, e.owner);
            end
            total++;
            assert (busy === e.busy) else begin
                bad++;
                $error("FAIL %s.busy observed=%b required=%b", e.tag, busy, e.busy);
            end
            total++;
            assert (talarm === e.talarm) else begin
                bad++;
                $error("FAIL %s.talarm observed=%b required=%b", e.tag, talarm, e.talarm);
            end
        end
    endtask

    task automatic tick();
        @(posedge __clk);
        #1;
    endtask

    // One clock step: record what the next edge must produce, then check it.
    task automatic cyc(input string tag, input logic [3:0] zw_e,
                       input logic [1:0] own_e, input logic busy_e,
                       input logic tal_e);
        expect_out(tag, zw_e, own_e, busy_e, tal_e);
        tick();
        check();
    endtask

    initial begin
        clo_ = 1'b0;
        zg   = '0;
        rok_ = 1'b1;
        ren_ = 1'b1;

        // Reset state before any clock edge.
        #5;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check();
        @(posedge __clk);
        #5 clo_ = 1'b1;
        cyc("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request: 1-cycle grant latency, answer, release, gap.
        zg = 4'b0001;
        cyc("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (3) cyc("t1_wait", 4'b0001, 2'd0, 1'b1, 1'b0);
        rok_ = 1'b0;
        cyc("t1_answer", 4'b0001, 2'd0, 1'b1, 1'b0);
        rok_ = 1'b1;
        repeat (2) cyc("t1_done_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        zg = 4'b0000;
        cyc("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t1_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Contention: lowest index wins, held request waits out the gap.
        zg = 4'b0110;
        cyc("t2_grant_lowest", 4'b0010, 2'd1, 1'b1, 1'b0);
        ren_ = 1'b0;
        cyc("t2_answer", 4'b0010, 2'd1, 1'b1, 1'b0);
        ren_ = 1'b1;
        zg = 4'b0100;
        cyc("t2_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t2_gap_block", 4'b0000, 2'd1, 1'b0, 1'b0);
        cyc("t2_next_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        rok_ = 1'b0;
        cyc("t2_answer2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rok_ = 1'b1;
        zg = 4'b0011;
        cyc("t2_release2", 4'b0000, 2'd2, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t2_gap2", 4'b0000, 2'd2, 1'b0, 1'b0);
        // Both builds pick index 0 here (round-robin pointer wraps past 3).
        cyc("t2_wrap_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        rok_ = 1'b0;
        cyc("t2_answer3", 4'b0001, 2'd0, 1'b1, 1'b0);
        rok_ = 1'b1;
        zg = 4'b0010;
        cyc("t2_release3", 4'b0000, 2'd0, 1'b0, 1'b0);
        zg = 4'b0011;
        repeat (GAP_TICKS) cyc("t2_gap3", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("t2_after_owner0", PRI_ZW, PRI_OWN, 1'b1, 1'b0);
        zg = 4'b0000;
        cyc("t2_release4", 4'b0000, PRI_OWN, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t2_gap4", 4'b0000, PRI_OWN, 1'b0, 1'b0);
        cyc("t2_idle", 4'b0000, PRI_OWN, 1'b0, 1'b0);

        // Timeout: alarm after TIMEOUT cycles, held ALARM_TICKS, permit kept.
        zg = 4'b0001;
        cyc("t3_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (TIMEOUT - 1) cyc("t3_count", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc("t3_alarm_on", 4'b0001, 2'd0, 1'b1, 1'b1);
        rok_ = 1'b0;
        repeat (ALARM_TICKS - 1) cyc("t3_alarm_hold", 4'b0001, 2'd0, 1'b1, 1'b1);
        rok_ = 1'b1;
        cyc("t3_alarm_off", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc("t3_done_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        zg = 4'b0000;
        cyc("t3_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t3_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("t3_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Answer on the timeout cycle wins: no alarm at all.
        zg = 4'b0001;
        cyc("t4_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (TIMEOUT - 1) cyc("t4_count", 4'b0001, 2'd0, 1'b1, 1'b0);
        ren_ = 1'b0;
        cyc("t4_answer_at_timeout", 4'b0001, 2'd0, 1'b1, 1'b0);
        ren_ = 1'b1;
        repeat (ALARM_TICKS + 1) cyc("t4_no_alarm", 4'b0001, 2'd0, 1'b1, 1'b0);
        zg = 4'b0000;
        cyc("t4_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t4_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("t4_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Abort at timer 10; pending request 3 is served after the gap.
        zg = 4'b0001;
        cyc("t5_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (10) cyc("t5_wait", 4'b0001, 2'd0, 1'b1, 1'b0);
        zg = 4'b1000;
        cyc("t5_abort", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t5_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("t5_pending_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        zg = 4'b0000;
        cyc("t5_release", 4'b0000, 2'd3, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t5_gap2", 4'b0000, 2'd3, 1'b0, 1'b0);
        cyc("t5_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Asynchronous clear in the middle of an alarm pulse.
        zg = 4'b0001;
        cyc("t6_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (TIMEOUT - 1) cyc("t6_count", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc("t6_alarm_on", 4'b0001, 2'd0, 1'b1, 1'b1);
        #4 clo_ = 1'b0;
        #1;
        expect_out("t6_async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check();
        #2 clo_ = 1'b1;
        cyc("t6_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        zg = 4'b0000;
        cyc("t6_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (GAP_TICKS) cyc("t6_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("t6_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover: observed=%0d entries required=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
Arbitrates system bus ownership between the rack modules (CPU P-X, channels, front panel) raising ZG bus requests, and returns a one-hot ZW permit. Supervises each granted cycle for a memory answer (ROK/REN). Raises the TALARM pulse when no answer arrives in time, and enforces a dead gap between owners. Sits at rack level between the module ZG/ZW lines and the bus answer lines; P-X consumes its zw bit and talarm.

Parameters:
NREQ, 4, number of requesters; index 0 = CPU; width of zg/zw.
TIMEOUT, 250, __clk cycles from grant to alarm without answer (5 us @ 50 MHz); range 2..255.
ALARM_TICKS, 3, talarm pulse length in cycles (60 ns @ 50 MHz); range 1..7.
GAP_TICKS, 1, idle cycles between release and next grant; range 1..3.

Ports:
__clk  in  1  system clock (50 MHz)
clo_  in  1  general clear; asynchronous, active-low
zg  in  NREQ  bus requests, active-high; bit i = module i
rok_  in  1  memory answer OK, active-low
ren_  in  1  memory answer EN (no such memory), active-low
zw  out  NREQ  bus permit, one-hot or zero; registered
owner  out  clog2(NREQ)  index of current/last owner; registered
busy  out  1  high while any zw bit is set
talarm  out  1  alarm pulse, no-answer timeout; registered

Behaviour:
- Reset (clo_ low, async): zw=0, owner=0, busy=0, talarm=0, timer=0, state IDLE, RR pointer=0. Reset mid-cycle drops the grant immediately with no alarm.
- Outputs registered on __clk rising edge; zg, rok_ and ren_ are sampled as synchronous to __clk.
- Answer = ~rok_ | ~ren_.
- State machine (states IDLE, GRANT, DONE, ALARM, GAP):
  - IDLE: if zg!=0, select winner by fixed priority (lowest index wins). Next edge: zw=onehot(winner), owner=winner, busy=1, timer=0, go to GRANT. Latency from zg rise to zw = 1 cycle.
  - GRANT: timer increments each cycle.
    - If answer: go to DONE.
    - Else if zg[owner]==0 (abort): clear zw, go to GAP, no alarm.
    - Else if timer==TIMEOUT-1: go to ALARM, talarm=1.
    - Answer and timeout in the same cycle: answer wins, no alarm.
  - ALARM: talarm held exactly ALARM_TICKS cycles. zw stays held. Then talarm=0 and go to DONE. Answers during ALARM are ignored.
  - DONE: hold zw until zg[owner]==0. Next edge: zw=0, busy=0, go to GAP. Further answers are ignored.
  - GAP: stay GAP_TICKS cycles, then IDLE. New requests are not granted during GAP; requests that arrive are not lost (level sensitive).
- Grant is never preempted; a higher-priority request waits for the owner to release.
- Requests from non-owners never affect the current cycle.
- zw is never multi-hot; a zw bit is never set while its zg bit is low in IDLE.
- Timer: 8 bit, saturates, cleared on each grant.

Optional Feature:
SYSBUS_RR_EN:
- Defined: round-robin arbitration. A pointer holds the index after the last owner. The winner is the first requesting index at or after the pointer, wrapping modulo NREQ. The pointer updates on each grant; reset value 0.
- Undefined: fixed priority, lowest index wins; no pointer register.
- All other timing is identical in both builds.

Test Plan:
- Single request: zg=0001 at cycle 0 -> zw=0001, owner=0 at cycle 1. rok_ low at cycle 5 -> DONE. zg=0 at cycle 8 -> zw=0 at cycle 9; no new grant before cycle 10.
- Contention, fixed priority: zg=0110 in IDLE -> zw=0010. Owner 1 releases -> after the 1-cycle gap zw=0100. Build with SYSBUS_RR_EN: after owner 1, zg=0011 -> zw=0001 (fixed build) vs zw=0001 (RR, pointer=2 wraps to 0). Second check with the pointer past 0: owner 0 just served, zg=0011 -> RR gives zw=0010.
- Timeout: grant with no rok_/ren_ -> talarm high exactly at timer 249 for 3 cycles, zw held throughout. Then release -> zw=0.
- Boundary, answer on timeout cycle: ren_ low exactly at timer==249 -> talarm never asserts; DONE entered.
- Abort: owner drops zg at timer 10 with no answer -> zw=0 next edge, talarm stays 0. Pending zg=1000 is granted after the gap.
- Async reset: clo_ pulled low mid-ALARM -> zw=0, talarm=0 immediately (no clock edge needed). After clo_ release with zg=0001 held -> zw=0001 one cycle later.
